// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited imem requests
// and buffers {PC+4, instruction} pairs in an in-order FIFO toward the IF/ID register.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_ins_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic          started_q;
    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];

    logic [CW:0] used_w;
    logic        issue_w, resp_keep_w, push_w, pop_w;

    assign used_w      = {1'b0, count_q} + {1'b0, outst_q} + {1'b0, drop_q};
    // started_q keeps requests off while reset is held and on the first cycle after it
    assign imem_req_o  = started_q && !redirect_i && (used_w < DEPTH_W);
    assign imem_addr_o = fetch_pc_q;
    assign issue_w     = imem_req_o && imem_gnt_i;
    assign resp_keep_w = imem_rvalid_i && (drop_q == '0);
    assign out_valid_o = (count_q != '0);
    assign push_w      = resp_keep_w && !redirect_i;
    assign pop_w       = out_valid_o && out_ready_i && !redirect_i;
    assign out_pc_o    = out_valid_o ? pc_mem_q[rd_ptr_q]  : '0;
    assign out_ins_o   = out_valid_o ? ins_mem_q[rd_ptr_q] : '0;

    always_comb begin
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (redirect_i) begin
            // every response still on its way, minus the one arriving now, becomes stale
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            outst_d    = '0;
            drop_d     = drop_q + outst_q - CW'(imem_rvalid_i);
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            resp_pc_d  = {redirect_pc_i[31:2], 2'b00};
        end else begin
            if (issue_w) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outst_d = outst_q + CW'(issue_w) - CW'(resp_keep_w);
            if (imem_rvalid_i && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            if (resp_keep_w) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push_w) - CW'(pop_w);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            started_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            started_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_w) begin
            pc_mem_q[wr_ptr_q]  <= resp_pc_q + 32'd4;
            ins_mem_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

    // the credit rule makes a push into a full FIFO (without a pop) impossible
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(push_w && !pop_w && (count_q == CW'(DEPTH))));
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: in-order memory model with programmable latency and an
// expected-output queue filled on every issued fetch and drained on every accepted pop.
module tb_if_fetch_queue;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt = 1'b1;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_ins;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          issue_cnt = 0;
    int          pop_cnt = 0;
    logic [31:0] exp_fetch = RST_PC;
    logic [63:0] sb[$];
    mreq_t       mq[$];

    if_fetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .out_ins_o(out_ins)
    );

    always #5 clk = ~clk;

    // Monitor: expected fetch address, scoreboard push on issue, compare on pop.
    always @(posedge clk) begin
        logic [63:0] e;
        cyc++;
        if (rst_n && imem_req && gnt) begin
            mq.push_back('{addr: imem_addr, due: cyc + lat});
            issue_cnt++;
        end
        if (!rst_n) begin
            sb.delete();
            exp_fetch = RST_PC;
        end else if (redirect) begin
            n_tests++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL req_in_redirect: imem_req=%b, required 0", imem_req);
            end
            sb.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
        end else begin
            if (out_valid && out_ready) begin
                pop_cnt++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pop: out_pc=%h out_ins=%h, nothing expected", out_pc, out_ins);
                end else begin
                    e = sb.pop_front();
                    if (out_pc !== e[63:32] || out_ins !== e[31:0]) begin
                        n_fail++;
                        $display("FAIL pop_data: got pc=%h ins=%h, required pc=%h ins=%h",
                                 out_pc, out_ins, e[63:32], e[31:0]);
                    end
                end
            end
            if (imem_req && gnt) begin
                n_tests++;
                if (imem_addr !== exp_fetch) begin
                    n_fail++;
                    $display("FAIL fetch_addr: got %h, required %h", imem_addr, exp_fetch);
                end
                sb.push_back({exp_fetch + 32'd4, exp_fetch});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
    end

    // Memory: data equals address; responses strictly in request order.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            rvalid = 1'b0;
        end else if (mq.size() > 0 && mq[0].due == cyc + 1) begin
            rvalid = 1'b1;
            rdata  = mq[0].addr;
            void'(mq.pop_front());
        end else begin
            rvalid = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect = 1'b0;
        mq.delete();
        rvalid = 1'b0;
        repeat (2) @(negedge clk);
        issue_cnt = 0;
        pop_cnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_for_valid(input int limit, input string tag);
        int k = 0;
        while (out_valid !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", tag, out_valid, k);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mq.delete();
        rvalid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: out_valid=%b imem_req=%b, required 0 0", out_valid, imem_req);
        end
        n_tests++;
        if (imem_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_addr: got %h, required %h", imem_addr, RST_PC);
        end
        n_tests++;
        if (out_pc !== 32'h0 || out_ins !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: out_pc=%h out_ins=%h, required 0 0", out_pc, out_ins);
        end
    endtask

    task automatic test_stream_wrap();
        int p0;
        lat = 1; gnt = 1'b1; out_ready = 1'b1;
        do_reset();
        wait_for_valid(10, "stream");
        n_tests++;
        if (out_pc !== 32'hFFFF_FFFC || out_ins !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL stream_first: got pc=%h ins=%h, required pc=fffffffc ins=fffffff8", out_pc, out_ins);
        end
        p0 = pop_cnt;
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_gap: cycle %0d out_valid=%b, required 1", i, out_valid);
            end
            @(negedge clk);
        end
        n_tests++;
        if (pop_cnt - p0 !== 12) begin
            n_fail++;
            $display("FAIL stream_pops: got %0d, required 12", pop_cnt - p0);
        end
    endtask

    task automatic test_stall();
        int p0;
        lat = 1; gnt = 1'b1; out_ready = 1'b0;
        do_reset();
        wait_for_valid(10, "stall");
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== RST_PC + 32'd4 || out_ins !== RST_PC) begin
                n_fail++;
                $display("FAIL stall_head: valid=%b pc=%h ins=%h, required 1 %h %h",
                         out_valid, out_pc, out_ins, RST_PC + 32'd4, RST_PC);
            end
            @(negedge clk);
        end
        n_tests++;
        if (issue_cnt !== 4) begin
            n_fail++;
            $display("FAIL stall_issues: got %0d, required 4", issue_cnt);
        end
        out_ready = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL release_gap: cycle %0d out_valid=%b, required 1", i, out_valid);
            end
            @(negedge clk);
        end
        n_tests++;
        if (pop_cnt - p0 !== 10) begin
            n_fail++;
            $display("FAIL release_pops: got %0d, required 10", pop_cnt - p0);
        end
    endtask

    task automatic redirect_and_check(input logic [31:0] tgt, input string tag);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        @(negedge clk);
        redirect = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_flush: out_valid=%b at R+1, required 0", tag, out_valid);
        end
        wait_for_valid(20, tag);
        n_tests++;
        if (out_pc !== t + 32'd4 || out_ins !== t) begin
            n_fail++;
            $display("FAIL %s_target: got pc=%h ins=%h, required pc=%h ins=%h", tag, out_pc, out_ins, t + 32'd4, t);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_redirect();
        lat = 3; gnt = 1'b1; out_ready = 1'b1;
        do_reset();
        wait_for_valid(15, "redir_pre");
        repeat (3) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        redirect_and_check(32'h100, "redirect");
    endtask

    task automatic test_redirect_same_cycle();
        int k = 0;
        lat = 3; out_ready = 1'b1;
        while (!(rvalid === 1'b1 && out_valid === 1'b1) && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!(rvalid === 1'b1 && out_valid === 1'b1)) begin
            n_fail++;
            $display("FAIL same_cycle_setup: rvalid=%b out_valid=%b, required 1 1", rvalid, out_valid);
        end
        redirect = 1'b1;
        redirect_pc = 32'h200;
        redirect_and_check(32'h200, "redir_same");
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        redirect_pc = 32'h403;
        redirect_and_check(32'h403, "b2b");
    endtask

    task automatic test_random_backpressure();
        int p0;
        lat = 2;
        p0 = pop_cnt;
        for (int i = 0; i < 60; i++) begin
            gnt = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        gnt = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++;
        if (pop_cnt - p0 < 10) begin
            n_fail++;
            $display("FAIL random_progress: %0d pops, required at least 10", pop_cnt - p0);
        end
    endtask

    task automatic test_midstream_reset();
        int k = 0;
        lat = 1; gnt = 1'b1; out_ready = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        mq.delete();
        rvalid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: out_valid=%b imem_req=%b, required 0 0", out_valid, imem_req);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        while (imem_req !== 1'b1 && k < 5) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL midreset_first_req: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RST_PC);
        end
        wait_for_valid(10, "midreset");
        n_tests++;
        if (out_pc !== RST_PC + 32'd4) begin
            n_fail++;
            $display("FAIL midreset_first_out: got pc=%h, required %h", out_pc, RST_PC + 32'd4);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream_wrap();
        test_stall();
        test_redirect();
        test_redirect_same_cycle();
        test_back_to_back();
        test_random_backpressure();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
